// File: rtl/queue_enq_arbiter.sv
// Round-robin arbiter that shares one queue enqueue port among N_REQ producers.
// An owner may keep the port for up to MAX_BURST back-to-back transfers before
// priority rotates. The arbiter is zero-latency: it holds no payload storage, and
// it gates transfers with the same accept rule the queue itself uses.
module queue_enq_arbiter #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned MAX_BURST = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid_i,
  input  logic [N_REQ*WIDTH-1:0]   req_data_i,
  output logic [N_REQ-1:0]         req_ready_o,
  input  logic                     q_full_i,
  input  logic                     q_dequeue_i,
  output logic                     q_enqueue_o,
  output logic [WIDTH-1:0]         q_data_o,
  output logic                     grant_valid_o,
  output logic [$clog2(N_REQ)-1:0] grant_id_o
);

  localparam int unsigned IdW  = $clog2(N_REQ);
  localparam int unsigned CntW = $clog2(MAX_BURST + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_BURST);

  logic [IdW-1:0]  owner_q, owner_d;
  logic [CntW-1:0] burst_q, burst_d;

  logic            can_enq;
  logic            hold;
  logic            any_valid;
  logic            found;
  logic            xfer;
  logic [IdW-1:0]  grant;
  int unsigned     search_idx;

  // Owner and burst counter; reset puts requester 0 at top priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= IdW'(N_REQ - 1);
      burst_q <= '0;
    end else begin
      owner_q <= owner_d;
      burst_q <= burst_d;
    end
  end

  // Grant selection: keep an unfinished burst, otherwise search after the owner.
  always_comb begin
    can_enq    = !q_full_i || q_dequeue_i;
    any_valid  = |req_valid_i;
    hold       = (burst_q != '0) && (burst_q < MaxCnt) && req_valid_i[owner_q];
    grant      = '0;
    found      = 1'b0;
    search_idx = 0;
    if (hold) begin
      grant = owner_q;
    end else begin
      // The owner itself is visited last (i == N_REQ), giving it lowest priority.
      for (int unsigned i = 1; i <= N_REQ; i++) begin
        search_idx = (32'(owner_q) + i) % N_REQ;
        if (!found && req_valid_i[IdW'(search_idx)]) begin
          grant = IdW'(search_idx);
          found = 1'b1;
        end
      end
    end
    xfer = any_valid && can_enq;
  end

  // Handshake outputs; payload is muxed straight through from the granted lane.
  always_comb begin
    req_ready_o   = '0;
    grant_valid_o = any_valid;
    grant_id_o    = any_valid ? grant : '0;
    q_enqueue_o   = xfer;
    q_data_o      = '0;
    if (xfer) begin
      req_ready_o[grant] = 1'b1;
    end
    if (any_valid) begin
      q_data_o = req_data_i[32'(grant)*WIDTH +: WIDTH];
    end
  end

  // Next-state: advance on a transfer, release the burst if the owner went idle.
  always_comb begin
    owner_d = owner_q;
    burst_d = burst_q;
    if (xfer) begin
      owner_d = grant;
      // hold implies burst_q < MAX_BURST, so the increment cannot overflow.
      burst_d = hold ? burst_q + CntW'(1) : CntW'(1);
    end else if (!req_valid_i[owner_q]) begin
      burst_d = '0;
    end
  end

endmodule

// File: tb/tb_queue_enq_arbiter.sv
// Scoreboard bench: drivers push hand-computed expectations per cycle, monitors
// pop and compare on the falling edge.
module tb_queue_enq_arbiter;

  typedef struct {
    logic        gv;
    logic [1:0]  id;
    logic        enq;
    logic [31:0] data;
    logic [3:0]  ready;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  exp_t exp_a[$];
  exp_t exp_b[$];

  // Instance A: defaults (4 requesters, burst of 2).
  logic         rst_a = 1'b1;
  logic [3:0]   valid_a = '0;
  logic [127:0] data_a = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
  logic [3:0]   ready_a;
  logic         full_a = 1'b0, deq_a = 1'b0;
  logic         enq_a, gv_a;
  logic [31:0]  qdata_a;
  logic [1:0]   id_a;

  queue_enq_arbiter #(.N_REQ(4), .WIDTH(32), .MAX_BURST(2)) dut_a (
    .clk          (clk),
    .rst          (rst_a),
    .req_valid_i  (valid_a),
    .req_data_i   (data_a),
    .req_ready_o  (ready_a),
    .q_full_i     (full_a),
    .q_dequeue_i  (deq_a),
    .q_enqueue_o  (enq_a),
    .q_data_o     (qdata_a),
    .grant_valid_o(gv_a),
    .grant_id_o   (id_a)
  );

  // Instance B: 3 requesters, pure round-robin.
  logic        rst_b = 1'b1;
  logic [2:0]  valid_b = '0;
  logic [23:0] data_b = {8'hB2, 8'hB1, 8'hB0};
  logic [2:0]  ready_b;
  logic        enq_b, gv_b;
  logic [7:0]  qdata_b;
  logic [1:0]  id_b;

  queue_enq_arbiter #(.N_REQ(3), .WIDTH(8), .MAX_BURST(1)) dut_b (
    .clk          (clk),
    .rst          (rst_b),
    .req_valid_i  (valid_b),
    .req_data_i   (data_b),
    .req_ready_o  (ready_b),
    .q_full_i     (1'b0),
    .q_dequeue_i  (1'b0),
    .q_enqueue_o  (enq_b),
    .q_data_o     (qdata_b),
    .grant_valid_o(gv_b),
    .grant_id_o   (id_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic gv, input int id, input logic enq,
                              input logic [31:0] base);
    exp_t e;
    e.gv    = gv;
    e.id    = 2'(id);
    e.enq   = enq;
    e.data  = gv ? base + 32'(id) : 32'h0;
    e.ready = enq ? (4'b0001 << id) : 4'b0000;
    return e;
  endfunction

  task automatic drive_a(input logic [3:0] v, input logic full, input logic deq,
                         input logic gv, input int id, input logic enq);
    @(posedge clk);
    #1;
    rst_a   = 1'b0;
    valid_a = v;
    full_a  = full;
    deq_a   = deq;
    exp_a.push_back(mk(gv, id, enq, 32'hA0));
  endtask

  // Raise rst for the next edge; that cycle is not checked.
  task automatic reset_a();
    @(posedge clk);
    #1;
    rst_a = 1'b1;
  endtask

  task automatic drive_b(input logic [2:0] v, input int id);
    @(posedge clk);
    #1;
    rst_b   = 1'b0;
    valid_b = v;
    exp_b.push_back(mk(|v, id, |v, 32'hB0));
  endtask

  exp_t ea, eb;

  // Monitor A
  always @(negedge clk) begin
    if (exp_a.size() != 0) begin
      ea = exp_a.pop_front();
      chk("a_grant_valid", 32'(gv_a), 32'(ea.gv));
      chk("a_grant_id", 32'(id_a), 32'(ea.id));
      chk("a_enqueue", 32'(enq_a), 32'(ea.enq));
      chk("a_data", qdata_a, ea.data);
      chk("a_ready", 32'(ready_a), 32'(ea.ready));
    end
  end

  // Monitor B
  always @(negedge clk) begin
    if (exp_b.size() != 0) begin
      eb = exp_b.pop_front();
      chk("b_grant_id", 32'(id_b), 32'(eb.id));
      chk("b_enqueue", 32'(enq_b), 32'(eb.enq));
      chk("b_data", 32'(qdata_b), eb.data[7:0]);
      chk("b_ready", 32'(ready_b), 32'(eb.ready[2:0]));
    end
  end

  initial begin
    // Reset state: no requests, all outputs zero.
    drive_a(4'b0000, 1'b0, 1'b0, 1'b0, 0, 1'b0);

    // 1: all valid, bursts of two rotate 0,0,1,1,2,2,3,3,0,0.
    begin
      int seq1[10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
      foreach (seq1[i]) drive_a(4'b1111, 1'b0, 1'b0, 1'b1, seq1[i], 1'b1);
    end

    // 2: lone requester 2 keeps full throughput across burst boundaries.
    reset_a();
    repeat (6) drive_a(4'b0100, 1'b0, 1'b0, 1'b1, 2, 1'b1);

    // 3: full queue stalls; dequeue lets one through; burst continues afterwards.
    reset_a();
    repeat (3) drive_a(4'b0011, 1'b1, 1'b0, 1'b1, 0, 1'b0);
    drive_a(4'b0011, 1'b1, 1'b1, 1'b1, 0, 1'b1);
    drive_a(4'b0011, 1'b0, 1'b0, 1'b1, 0, 1'b1);

    // 4: owner 1 drops after one transfer -> 3 next; idle cycle releases burst.
    reset_a();
    drive_a(4'b0010, 1'b0, 1'b0, 1'b1, 1, 1'b1);
    drive_a(4'b1001, 1'b0, 1'b0, 1'b1, 3, 1'b1);
    drive_a(4'b0000, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    drive_a(4'b1001, 1'b0, 1'b0, 1'b1, 0, 1'b1);

    // 6: reset after requester 2's first burst transfer restarts at 0 with a fresh burst.
    reset_a();
    begin
      int seq6[5] = '{0, 0, 1, 1, 2};
      foreach (seq6[i]) drive_a(4'b1111, 1'b0, 1'b0, 1'b1, seq6[i], 1'b1);
    end
    reset_a();
    drive_a(4'b1111, 1'b0, 1'b0, 1'b1, 0, 1'b1);
    drive_a(4'b1111, 1'b0, 1'b0, 1'b1, 0, 1'b1);
    drive_a(4'b1111, 1'b0, 1'b0, 1'b1, 1, 1'b1);

    // 5: N_REQ=3, MAX_BURST=1, wrap-around 0,1,2,0,1,2.
    begin
      int seq5[6] = '{0, 1, 2, 0, 1, 2};
      foreach (seq5[i]) drive_b(3'b111, seq5[i]);
    end
    drive_b(3'b000, 0);

    // Drain the scoreboards within a bounded number of cycles.
    for (int i = 0; i < 10 && (exp_a.size() != 0 || exp_b.size() != 0); i++) @(posedge clk);
    @(posedge clk);
    checks++;
    if (exp_a.size() != 0 || exp_b.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_a.size() + exp_b.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/queue_enq_arbiter.md
Name: queue_enq_arbiter

Overview:
- Round-robin arbiter that shares the single enqueue port of one `queue` instance among N_REQ producers, for example decode lanes or functional units writing a shared buffer.
- Applies the same acceptance rule as `queue`, so a producer can enqueue into a full queue in the same cycle the consumer dequeues.
- Supports bounded burst ownership: a producer may keep the port for up to MAX_BURST consecutive transfers before priority rotates.

Parameters:
N_REQ, 4, number of requesters (at least 2)
WIDTH, 32, payload width; matches the queue WIDTH
MAX_BURST, 2, maximum consecutive transfers per owner (at least 1); 1 gives pure round-robin

Ports:
clk  input  1  clock
rst  input  1  reset
req_valid_i  input  N_REQ  per-requester valid
req_data_i  input  N_REQ*WIDTH  flattened payloads; requester k occupies bits [k*WIDTH +: WIDTH]
req_ready_o  output  N_REQ  per-requester ready, one-hot or zero
q_full_i  input  1  queue full_o
q_dequeue_i  input  1  queue dequeue_i, the same-cycle consumer pop
q_enqueue_o  output  1  drives queue enqueue_i
q_data_o  output  WIDTH  drives queue data_i
grant_valid_o  output  1  some requester currently holds the grant
grant_id_o  output  $clog2(N_REQ)  index of the granted requester

Behaviour:
- Interface decision: reset rst, synchronous, active-high; clock clk.
- State registers:
  - owner: $clog2(N_REQ) bits.
  - burst_cnt: $clog2(MAX_BURST+1) bits.
- Reset: owner <= N_REQ-1 and burst_cnt <= 0, so requester 0 has highest priority on the first cycle after reset.
- All outputs are combinational from state and inputs. With no valid requests after reset, every output is 0.
- can_enq = !q_full_i || q_dequeue_i. This is identical to the queue's accept condition.
- hold = (burst_cnt != 0) && (burst_cnt < MAX_BURST) && req_valid_i[owner].
- Grant selection:
  - If hold, g = owner.
  - Otherwise g = the first k with req_valid_i[k] set, searching owner+1, owner+2, … modulo N_REQ, with owner itself checked last.
  - grant_valid_o = |req_valid_i.
  - grant_id_o = g, or 0 when there is no grant.
- Handshake:
  - req_ready_o[g] = grant_valid_o && can_enq; every other ready bit is 0.
  - q_enqueue_o = grant_valid_o && can_enq.
  - q_data_o = the payload of requester g, or 0 when there is no grant.
  - A transfer is the cycle in which q_enqueue_o = 1.
  - A requester must hold valid and data stable until it sees ready. Withdrawing valid is legal but is not a transfer.
- Latency: zero cycles. The payload reaches the queue in the same cycle the grant and ready are given. There is no internal storage.
- State update on a transfer:
  - owner <= g.
  - burst_cnt <= burst_cnt+1 if hold, otherwise 1.
- State update on a cycle with no transfer:
  - If req_valid_i[owner] = 0, burst_cnt <= 0, which releases the burst.
  - Otherwise all state is held, so a stalled grant stays stable while inputs stay stable.
- Burst boundary: when burst_cnt = MAX_BURST, hold is false and the owner drops to lowest priority. If the owner is the only valid requester it is re-granted immediately with burst_cnt <= 1, so a lone requester keeps full throughput of one transfer per cycle.
- Full queue: while q_full_i = 1 and q_dequeue_i = 0, no transfer occurs and state is unchanged. With q_full_i = 1 and q_dequeue_i = 1, the transfer proceeds.
- Reset mid-burst: in the cycle rst is high, outputs still reflect the pre-reset state. The next cycle starts from owner = N_REQ-1 and burst_cnt = 0. The queue resets in the same cycle, so nothing is lost inconsistently.
- Wrap-around: the search index and owner+1 wrap modulo N_REQ, including for non-power-of-2 N_REQ.

Test Plan:
1. Defaults; all four valid continuously; q_full_i = 0 -> grant_id_o sequence 0,0,1,1,2,2,3,3,0,0 with q_enqueue_o = 1 every cycle, and q_data_o equals the matching payload, e.g. 0xA0 to 0xA3 for requesters 0 to 3.
2. Only requester 2 valid for 6 cycles -> grant_id_o = 2 and q_enqueue_o = 1 every cycle; burst_cnt sequence 1,2,1,2,1,2.
3. Requesters 0 and 1 valid; q_full_i = 1 and q_dequeue_i = 0 for 3 cycles -> req_ready_o = 0, q_enqueue_o = 0, grant_id_o stays 0. Then q_dequeue_i = 1 for one cycle -> one transfer from requester 0.
4. Requester 1 transfers once (burst_cnt = 1), then drops valid while requesters 0 and 3 are valid -> next grant is 3, not 0. A cycle with no valid requests clears burst_cnt to 0.
5. MAX_BURST = 1, N_REQ = 3; all valid -> grant sequence 0,1,2,0,1,2. Confirms wrap-around for non-power-of-2 N_REQ.
6. rst asserted after requester 2's first burst transfer, all still valid -> first post-reset grant is 0 and burst_cnt restarts at 1.
